mux_rr_reg: RTL and testbench

Parametrised, registered N-channel multiplexer with per-channel valid/ready handshakes and two selection modes: fixed select and round-robin. It generalises the combinational 4:1 mux to CH channels of WIDTH bits, adds a registered output stage with backpressure, and reports which channel produced each output word. It sits between several producer streams and one consumer stream.

---
 rtl/mux_rr_reg.sv | 127 ++++++++++++
 tb/tb_mux_rr_reg.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_reg.sv
// mux_rr_reg: registered CH-to-1 multiplexer with valid/ready handshakes.
//
// Selects one of CH producer channels and forwards its word into a single
// output register. Two grant modes are supported:
//   mode = 0 : fixed select, channel `sel` is granted when it is valid
//   mode = 1 : round-robin, the search starts at the channel after the one
//              that made the last round-robin transfer
// The output register accepts a new word whenever it is empty or being
// drained in the same cycle, so streaming runs at one word per clock.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   x        channel data, channel i at bits [i*WIDTH +: WIDTH]
//   x_valid  per-channel word present
//   x_ready  per-channel word accepted this cycle (combinational)
//   mode     0 = fixed select, 1 = round-robin
//   sel      channel index used when mode = 0
//   m        registered output word
//   m_valid  m holds a word
//   m_ready  consumer accepts m this cycle
//   m_ch     index of the channel that produced m
//
// SELW must equal clog2(CH). When CH is not a power of two, sel values at or
// above CH simply produce no grant.

module mux_rr_reg #(
  parameter int WIDTH = 1,
  parameter int CH    = 4,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH*WIDTH-1:0]   x,
  input  logic [CH-1:0]         x_valid,
  output logic [CH-1:0]         x_ready,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      m,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [SELW-1:0]       m_ch
);

  logic             load_en;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic [SELW-1:0]  ptr;        // channel of the last round-robin transfer

  // The reset term keeps every x_ready low while rst_n is asserted; without
  // it the empty output register would advertise readiness during reset.
  assign load_en = rst_n && (!m_valid || m_ready);

  // Grant selection.
  // NOTE: every signal driven here gets a default value at the top of the
  // block, so no path through the ifs/loops can leave it unassigned and
  // infer a latch.
  always_comb begin : grant_logic
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (!mode) begin
      for (int i = 0; i < CH; i++) begin
        if (sel == SELW'(i) && x_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
    end else begin
      // Round-robin in two prioritised passes. Loops run from the top index
      // down so that the lowest matching index is the last assignment and
      // therefore wins within each pass.
      // Pass 1 (fallback): lowest valid channel overall, i.e. the wrapped
      // part of the search order.
      for (int i = CH - 1; i >= 0; i--) begin
        if (x_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
      // Pass 2 (preferred): lowest valid channel strictly above ptr.
      for (int i = CH - 1; i >= 0; i--) begin
        if (x_valid[i] && i > int'(ptr)) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
    end
  end

  // Data mux and per-channel ready decode for the granted channel.
  always_comb begin : data_ready_logic
    grant_data = '0;
    x_ready    = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data = x[i*WIDTH +: WIDTH];
        x_ready[i] = load_en && grant_valid;
      end
    end
  end

  // Output register and round-robin pointer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= '0;
      m_valid <= 1'b0;
      m_ch    <= '0;
      ptr     <= SELW'(CH - 1);   // first round-robin search starts at 0
    end else if (load_en && grant_valid) begin
      // Covers both loading an empty register and drain-plus-reload in the
      // same cycle.
      m       <= grant_data;
      m_ch    <= grant_idx;
      m_valid <= 1'b1;
      if (mode) begin
        ptr <= grant_idx;
      end
    end else if (m_ready) begin
      // Drained with nothing to replace it; data and index stay as they were.
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Testbench for mux_rr_reg. Two instances run side by side on one clock:
//   dut_a : CH = 4, WIDTH = 1 (directed fixed-select / round-robin tests)
//   dut_b : CH = 8, WIDTH = 8 (width/count scaling)
// A behavioural model of each instance is stepped every clock by tick() and
// compared against x_ready before the edge and m/m_valid/m_ch after it.

module tb_mux_rr_reg;

  logic clk = 1'b0;
  logic rst_n;

  // dut_a signals
  logic [3:0]  xa, va, ra;
  logic        mode_a, mva, mra;
  logic [1:0]  sel_a, mcha;
  logic [0:0]  ma;

  // dut_b signals
  logic [63:0] xb;
  logic [7:0]  vb, rb, mb;
  logic        mode_b, mvb, mrb;
  logic [2:0]  sel_b, mchb;

  int errors = 0;
  int checks = 0;

  // Model state, index 0 = dut_a, 1 = dut_b
  logic [7:0] mdl_m   [2];
  bit         mdl_v   [2];
  int         mdl_ch  [2];
  int         mdl_ptr [2];

  mux_rr_reg #(.WIDTH(1), .CH(4), .SELW(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .x(xa), .x_valid(va), .x_ready(ra),
    .mode(mode_a), .sel(sel_a), .m(ma), .m_valid(mva), .m_ready(mra),
    .m_ch(mcha)
  );

  mux_rr_reg #(.WIDTH(8), .CH(8), .SELW(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .x(xb), .x_valid(vb), .x_ready(rb),
    .mode(mode_b), .sel(sel_b), .m(mb), .m_valid(mvb), .m_ready(mrb),
    .m_ch(mchb)
  );

  always #5 clk = ~clk;

  // Which channel the specification's rules grant, or -1 for none.
  function automatic int ref_grant(int nch, bit md, int sl, logic [7:0] vv, int p);
    if (!md) begin
      if (sl < nch && vv[sl]) return sl;
      return -1;
    end
    for (int k = 1; k <= nch; k++) begin
      int c;
      c = (p + k) % nch;
      if (vv[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mdl_m[d]  = 8'd0;
      mdl_v[d]  = 1'b0;
      mdl_ch[d] = 0;
    end
    mdl_ptr[0] = 3;
    mdl_ptr[1] = 7;
  endtask

  // One clock of both DUTs against the model. Inputs must be stable.
  task automatic tick();
    int         g   [2];
    bit         ld  [2];
    logic [7:0] exp_r, got_r, vv, got_m, got_ch;
    bit         md, mr, got_v;
    int         nch, sl;
    #1;
    for (int d = 0; d < 2; d++) begin
      nch = (d == 1) ? 8 : 4;
      vv  = (d == 1) ? vb : {4'b0, va};
      md  = (d == 1) ? mode_b : mode_a;
      sl  = (d == 1) ? int'(sel_b) : int'(sel_a);
      mr  = (d == 1) ? mrb : mra;
      g[d]  = ref_grant(nch, md, sl, vv, mdl_ptr[d]);
      ld[d] = !mdl_v[d] || mr;
      exp_r = (ld[d] && g[d] >= 0) ? 8'(1 << g[d]) : 8'd0;
      got_r = (d == 1) ? rb : {4'b0, ra};
      checks++;
      if (got_r !== exp_r) begin
        errors++;
        $display("FAIL x_ready dut%0d: got %b expected %b", d, got_r, exp_r);
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      md = (d == 1) ? mode_b : mode_a;
      mr = (d == 1) ? mrb : mra;
      if (ld[d] && g[d] >= 0) begin
        mdl_m[d]  = (d == 1) ? xb[g[d]*8 +: 8] : {7'b0, xa[g[d]]};
        mdl_ch[d] = g[d];
        mdl_v[d]  = 1'b1;
        if (md) mdl_ptr[d] = g[d];
      end else if (mr) begin
        mdl_v[d] = 1'b0;
      end
      got_m  = (d == 1) ? mb : {7'b0, ma};
      got_v  = (d == 1) ? mvb : mva;
      got_ch = (d == 1) ? {5'b0, mchb} : {6'b0, mcha};
      checks++;
      if (got_v !== mdl_v[d]) begin
        errors++;
        $display("FAIL m_valid dut%0d: got %b expected %b", d, got_v, mdl_v[d]);
      end
      checks++;
      if (got_m !== mdl_m[d]) begin
        errors++;
        $display("FAIL m dut%0d: got %h expected %h", d, got_m, mdl_m[d]);
      end
      checks++;
      if (got_ch !== 8'(mdl_ch[d])) begin
        errors++;
        $display("FAIL m_ch dut%0d: got %0d expected %0d", d, got_ch, mdl_ch[d]);
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_b();
    xb = '0; vb = '0; mode_b = 1'b0; sel_b = '0; mrb = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    idle_b();
    mode_a = 1'b1; va = 4'b1111; xa = 4'b1010; mra = 1'b1;
    mode_b = 1'b1; vb = 8'hff; xb = 64'h0123_4567_89ab_cdef;
    tick();
    tick();
    checks++;
    if (mva !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre m_valid: got %b expected 1", mva);
    end
    // Assert reset between edges and look immediately.
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({ma, mva, mcha, ra} !== 8'b0) begin
      errors++;
      $display("FAIL reset_async dut0: m=%b m_valid=%b m_ch=%0d x_ready=%b expected all 0",
               ma, mva, mcha, ra);
    end
    checks++;
    if ({mb, mvb, mchb, rb} !== 20'b0) begin
      errors++;
      $display("FAIL reset_async dut1: m=%h m_valid=%b m_ch=%0d x_ready=%b expected all 0",
               mb, mvb, mchb, rb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // First load after reset: round-robin starts at channel 0.
    tick();
    checks++;
    if (mcha !== 2'd0 || mva !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_load: m_ch=%0d m_valid=%b expected 0/1", mcha, mva);
    end
  endtask

  task automatic test_fixed_select();
    logic [3:0] exp_m;
    apply_reset();
    idle_b();
    exp_m  = 4'b0011;            // m expected for sel = 0,1,2,3 (bit s)
    mode_a = 1'b0; xa = 4'b0011; va = 4'b1111; mra = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s);
      tick();
      checks++;
      if (ma[0] !== exp_m[s] || mcha !== 2'(s)) begin
        errors++;
        $display("FAIL fixed_sel%0d: m=%b m_ch=%0d expected %b/%0d", s, ma, mcha, exp_m[s], s);
      end
    end
    sel_a = 2'd2; va = 4'b1011;
    #1;
    checks++;
    if (ra !== 4'b0000) begin
      errors++;
      $display("FAIL fixed_invalid x_ready: got %b expected 0000", ra);
    end
    tick();
    checks++;
    if (mva !== 1'b0) begin
      errors++;
      $display("FAIL fixed_invalid m_valid: got %b expected 0", mva);
    end
  endtask

  task automatic test_round_robin();
    int exp_all [6] = '{0, 1, 2, 3, 0, 1};
    int exp_alt [4] = '{0, 2, 0, 2};
    apply_reset();
    idle_b();
    mode_a = 1'b1; va = 4'b1111; mra = 1'b1; sel_a = 2'd0;
    for (int k = 0; k < 6; k++) begin
      xa = 4'($urandom);
      tick();
      checks++;
      if (mcha !== 2'(exp_all[k])) begin
        errors++;
        $display("FAIL rr_all step%0d: m_ch=%0d expected %0d", k, mcha, exp_all[k]);
      end
    end
    apply_reset();
    va = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      xa = 4'($urandom);
      tick();
      checks++;
      if (mcha !== 2'(exp_alt[k])) begin
        errors++;
        $display("FAIL rr_0101 step%0d: m_ch=%0d expected %0d", k, mcha, exp_alt[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [0:0] held;
    apply_reset();
    idle_b();
    mode_a = 1'b1; va = 4'b1111; mra = 1'b1; xa = 4'b0010;
    tick();
    tick();
    held = ma;
    mra  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      xa = 4'($urandom);
      tick();
      checks++;
      if (mcha !== 2'd1 || ma !== held || mva !== 1'b1 || ra !== 4'b0000) begin
        errors++;
        $display("FAIL backpressure cyc%0d: m=%b m_ch=%0d m_valid=%b x_ready=%b expected %b/1/1/0000",
                 k, ma, mcha, mva, ra, held);
      end
    end
    mra = 1'b1; xa = 4'b0100;
    tick();
    checks++;
    if (mcha !== 2'd2 || ma !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: m_ch=%0d m=%b expected 2/1", mcha, ma);
    end
    tick();
    checks++;
    if (mcha !== 2'd3 || ma !== 1'b0) begin
      errors++;
      $display("FAIL bp_next: m_ch=%0d m=%b expected 3/0", mcha, ma);
    end
  endtask

  task automatic test_mode_switch();
    apply_reset();
    idle_b();
    mode_a = 1'b1; va = 4'b1111; mra = 1'b1; xa = 4'b1001; sel_a = 2'd0;
    tick();
    tick();
    mode_a = 1'b0; sel_a = 2'd3;
    tick();
    checks++;
    if (mcha !== 2'd3 || ma !== 1'b1) begin
      errors++;
      $display("FAIL mode0_transfer: m_ch=%0d m=%b expected 3/1", mcha, ma);
    end
    mode_a = 1'b1;
    tick();
    checks++;
    if (mcha !== 2'd2) begin
      errors++;
      $display("FAIL mode_switch_ptr: m_ch=%0d expected 2", mcha);
    end
  endtask

  task automatic test_scaling();
    apply_reset();
    mode_a = 1'b0; va = 4'b0000; mra = 1'b1;
    mode_b = 1'b1; vb = 8'hff; mrb = 1'b1; sel_b = 3'd0;
    for (int i = 0; i < 8; i++) xb[i*8 +: 8] = 8'(i*16 + 1);
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++;
      if (mchb !== 3'(k % 8) || mb !== 8'((k % 8)*16 + 1)) begin
        errors++;
        $display("FAIL scaling step%0d: m_ch=%0d m=%h expected %0d/%h",
                 k, mchb, mb, k % 8, 8'((k % 8)*16 + 1));
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      xa = 4'($urandom);  va = 4'($urandom);  mode_a = 1'($urandom);
      sel_a = 2'($urandom); mra = ($urandom_range(0, 3) != 0);
      xb = {$urandom, $urandom}; vb = 8'($urandom); mode_b = ($urandom_range(0, 3) != 0);
      sel_b = 3'($urandom); mrb = ($urandom_range(0, 3) != 0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    xa = '0; va = '0; mode_a = 1'b0; sel_a = '0; mra = 1'b0;
    idle_b();
    model_reset();
    test_reset();
    test_fixed_select();
    test_round_robin();
    test_backpressure();
    test_mode_switch();
    test_scaling();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
